// File: rtl/leitor_permutacao.sv
// Consumer of the permutation-generator interface: validates a captured 4x2-bit
// permutation and issues its indices over a valid/ack handshake. Optional rank output: RANK_OUT_EN.
module leitor_permutacao (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] perm,
  input  logic       ready,
  input  logic       flush,
  output logic [1:0] idx,
  output logic       idx_valid,
  input  logic       idx_ack,
  output logic [1:0] slot,
  output logic       busy,
  output logic       done,
  output logic       perm_err,
  output logic [4:0] rank
);

  typedef enum logic [1:0] {IDLE, CHECK, EMIT, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] perm_r;
  logic [1:0] slot_r;
  logic [1:0] p0, p1, p2, p3;
  logic [1:0] sel_field;
  logic       distinct;

  assign p0 = perm_r[7:6];
  assign p1 = perm_r[5:4];
  assign p2 = perm_r[3:2];
  assign p3 = perm_r[1:0];

  assign distinct = (p0 != p1) && (p0 != p2) && (p0 != p3) &&
                    (p1 != p2) && (p1 != p3) && (p2 != p3);

  always_comb begin
    sel_field = p0;
    case (slot_r)
      2'd0: sel_field = p0;
      2'd1: sel_field = p1;
      2'd2: sel_field = p2;
      2'd3: sel_field = p3;
      default: sel_field = p0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    idx_valid = 1'b0;
    idx       = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (ready) state_nx = CHECK;
        CHECK: state_nx = distinct ? EMIT : IDLE;
        EMIT:  if (idx_ack && slot_r == 2'd3) state_nx = DONE;
        DONE:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
    if (state == EMIT) begin
      idx_valid = 1'b1;
      idx       = sel_field;
    end
    if (state == DONE) done = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perm_r   <= '0;
      slot_r   <= '0;
      perm_err <= 1'b0;
    end else if (flush) begin
      slot_r <= '0;
    end else begin
      case (state)
        IDLE: if (ready) begin
          perm_r   <= perm;
          perm_err <= 1'b0;
        end
        CHECK: begin
          slot_r <= '0;
          if (!distinct) perm_err <= 1'b1;
        end
        EMIT: if (idx_ack && slot_r != 2'd3) slot_r <= slot_r + 2'd1;
        DONE: slot_r <= '0;
        default: slot_r <= '0;
      endcase
    end
  end

  assign slot = slot_r;

`ifdef RANK_OUT_EN
  // b counts values other than p0 below p1, i.e. p1 shifted down when p0 < p1
  logic [1:0] b;
  logic [4:0] rank_calc;
  logic [4:0] rank_r;

  assign b         = p1 - {1'b0, (p1 > p0)};
  assign rank_calc = ({3'b000, p0} * 5'd6) + {2'b00, b, 1'b0} + {4'b0000, (p2 > p3)};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                  rank_r <= '0;
    else if (!flush && state == CHECK && distinct) rank_r <= rank_calc;
  end

  assign rank = rank_r;
`else
  assign rank = '0;
`endif

endmodule
